mdu_unit: RTL and testbench

//   Parametrised multi-cycle multiply/divide unit with HI/LO registers; it extends the

---
 rtl/mdu_unit_pkg.sv | 28 ++
 rtl/mdu_counter.sv | 32 +++
 rtl/mdu_unit.sv | 132 +++++++++++++
 tb/tb_mdu_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mdu_unit_pkg.sv
// rtl/mdu_unit_pkg.sv - shared op encodings and default cycle counts for the MDU and ALU decoder
// Purpose: op codes MDU_NONE..MDU_MTLO and default multi-cycle latencies.
// Ports: none (package).
package mdu_unit_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;

  localparam int MDU_WIDTH_DEF       = 32;
  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  // Ops that occupy the unit for several cycles and must stall dependents.
  function automatic logic mdu_is_long(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // Ops the unit accepts at all (long ops plus HI/LO moves).
  function automatic logic mdu_is_valid(input logic [3:0] op);
    return mdu_is_long(op) || (op == MDU_MTHI) || (op == MDU_MTLO);
  endfunction

endpackage

// File: rtl/mdu_counter.sv
// rtl/mdu_counter.sv - loadable down-counter that stops at zero
// Purpose: tracks remaining busy cycles of a multi-cycle MDU operation.
// Ports:
//   clk, reset   clock and synchronous active-high reset (count -> 0)
//   load         load load_val this cycle (wins over counting)
//   load_val     CW-bit start value
//   done         high while the count is zero
module mdu_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
// Purpose: executes MULT/MULTU/DIV/DIVU with a fixed latency and MTHI/MTLO in one cycle.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   start, op    op valid this cycle and its MDU_* encoding
//   A, B         rs / rt operands
//   busy         long operation in flight
//   stall_req    combinational stall request to the hazard unit
//   hi, lo       architectural HI/LO registers
//   div_zero     sticky divide-by-zero flag
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int WIDTH       = MDU_WIDTH_DEF,
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic accept, accept_long, is_div, retire, cnt_done;
  logic [CW-1:0] cnt_load;
  logic [WIDTH-1:0] pend_hi, pend_lo;
  logic [WIDTH-1:0] res_hi, res_lo;

  // Datapath intermediates
  logic             sgn, neg_a, neg_b, b_zero;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic [WIDTH-1:0] dvd, dvs, uq, ur, q, r;

  assign accept      = start && !busy && mdu_is_valid(op);
  assign accept_long = accept && mdu_is_long(op);
  assign is_div      = (op == MDU_DIV) || (op == MDU_DIVU);
  assign stall_req   = busy || (start && mdu_is_long(op));
  assign cnt_load    = is_div ? DIV_LOAD : MULT_LOAD;
  assign retire      = busy && cnt_done;

  mdu_counter #(.CW(CW)) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept_long),
    .load_val (cnt_load),
    .done     (cnt_done)
  );

  always_comb begin
    sgn    = (op == MDU_MULT) || (op == MDU_DIV);
    neg_a  = sgn && A[WIDTH-1];
    neg_b  = sgn && B[WIDTH-1];
    b_zero = (B == '0);

    // Low 2*WIDTH bits of the product of the extended operands equal the
    // signed product when sign-extended, so one multiplier serves both ops.
    ext_a = sgn ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
    ext_b = sgn ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
    prod  = ext_a * ext_b;

    // Signed divide via magnitudes; divisor forced to 1 on zero so the
    // divider never sees a zero divisor (result is overridden below).
    dvd = neg_a ? (~A + ONE) : A;
    dvs = b_zero ? ONE : (neg_b ? (~B + ONE) : B);
    uq  = dvd / dvs;
    ur  = dvd % dvs;
    q   = (neg_a ^ neg_b) ? (~uq + ONE) : uq;
    r   = neg_a ? (~ur + ONE) : ur;

    if (is_div) begin
      if (b_zero) begin
        res_hi = A;
        res_lo = '1;
      end else if (sgn && (A == MIN_NEG) && (B == '1)) begin
        res_hi = '0;
        res_lo = A;
      end else begin
        res_hi = r;
        res_lo = q;
      end
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      pend_hi  <= '0;
      pend_lo  <= '0;
      div_zero <= 1'b0;
    end else begin
      if (retire) begin
        hi   <= pend_hi;
        lo   <= pend_lo;
        busy <= 1'b0;
      end
      if (accept) begin
        if (op == MDU_MTHI) begin
          hi <= A;
        end else if (op == MDU_MTLO) begin
          lo <= A;
        end else begin
          pend_hi <= res_hi;
          pend_lo <= res_lo;
          busy    <= 1'b1;
          if (is_div && b_zero) begin
            div_zero <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - directed self-checking bench for mdu_unit
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  op;
  logic [31:0] A, B;
  logic        busy, stall_req, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with busy=1 until busy falls; bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      step();
    end
  endtask

  // Issue one long op, check stall/latency/hold, then the result.
  task automatic run_long(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int cyc,
                          input logic [31:0] ehi, input logic [31:0] elo);
    logic [31:0] old_hi, old_lo;
    int n;
    old_hi = hi;
    old_lo = lo;
    start = 1'b1; op = o; A = a; B = b;
    #1;
    check({tag, "_stall"}, 32'(stall_req), 32'd1);
    step();
    start = 1'b0; op = MDU_NONE;
    check({tag, "_hold_hi"}, hi, old_hi);
    check({tag, "_hold_lo"}, lo, old_lo);
    wait_idle(n);
    check({tag, "_cycles"}, n, cyc);
    check({tag, "_hi"}, hi, ehi);
    check({tag, "_lo"}, lo, elo);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; op = MDU_NONE; A = '0; B = '0;
    step(); step();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_dz", 32'(div_zero), 32'd0);

    // 1: MULT / MULTU
    run_long("mult",  MDU_MULT,  32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_long("multu", MDU_MULTU, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);

    // 2: DIV / DIVU
    run_long("div",  MDU_DIV,  32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_long("divu", MDU_DIVU, 32'd7,        32'd2, 10, 32'd1,        32'd3);
    run_long("div_pos", MDU_DIV, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD);

    // 3: overflow and divide by zero
    run_long("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);
    check("dz_before", 32'(div_zero), 32'd0);
    run_long("divu_z", MDU_DIVU, 32'd5, 32'd0, 10, 32'd5, 32'hFFFFFFFF);
    check("dz_set", 32'(div_zero), 32'd1);
    run_long("mult_after_dz", MDU_MULT, 32'd6, 32'd7, 5, 32'd0, 32'd42);
    check("dz_sticky", 32'(div_zero), 32'd1);

    // NONE / unknown ops with start are ignored
    start = 1'b1; op = MDU_NONE; A = 32'h55;
    #1; check("none_stall", 32'(stall_req), 32'd0);
    step();
    op = 4'd9;
    step();
    start = 1'b0;
    check("unk_busy", 32'(busy), 32'd0);
    check("unk_hi", hi, 32'd0);
    check("unk_lo", lo, 32'd42);

    // 4: MTHI while busy is ignored, MTLO after busy falls
    start = 1'b1; op = MDU_MULT; A = 32'hFFFFFFFE; B = 32'd3;
    step();
    start = 1'b0;
    step();
    start = 1'b1; op = MDU_MTHI; A = 32'h1234;
    step();
    start = 1'b0; op = MDU_NONE;
    wait_idle(n);
    check("ign_cycles", n, 3);
    check("ign_hi", hi, 32'hFFFFFFFF);
    check("ign_lo", lo, 32'hFFFFFFFA);
    start = 1'b1; op = MDU_MTLO; A = 32'hABCD;
    #1; check("mtlo_stall", 32'(stall_req), 32'd0);
    step();
    start = 1'b0; op = MDU_NONE;
    check("mtlo_lo", lo, 32'hABCD);
    check("mtlo_busy", 32'(busy), 32'd0);
    start = 1'b1; op = MDU_MTHI; A = 32'h1234;
    step();
    start = 1'b0;
    check("mthi_hi", hi, 32'h1234);

    // 6: back-to-back MULT
    start = 1'b1; op = MDU_MULT; A = 32'hFFFFFFFE; B = 32'd3;
    #1; check("b2b_stall", 32'(stall_req), 32'd1);
    step();
    start = 1'b0;
    wait_idle(n);
    check("b2b1_cycles", n, 5);
    check("b2b1_hi", hi, 32'hFFFFFFFF);
    check("b2b1_lo", lo, 32'hFFFFFFFA);
    start = 1'b1; op = MDU_MULT; A = 32'd5; B = 32'd7;
    step();
    start = 1'b0;
    check("b2b2_busy", 32'(busy), 32'd1);
    check("b2b2_hold", lo, 32'hFFFFFFFA);
    wait_idle(n);
    check("b2b2_cycles", n, 5);
    check("b2b2_hi", hi, 32'd0);
    check("b2b2_lo", lo, 32'd35);

    // 5: reset mid-DIV aborts with no late write
    start = 1'b1; op = MDU_DIVU; A = 32'd100; B = 32'd3;
    step();
    start = 1'b0;
    step(); step(); step();
    check("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_dz", 32'(div_zero), 32'd0);
    for (int i = 0; i < 10; i++) step();
    check("late_busy", 32'(busy), 32'd0);
    check("late_hi", hi, 32'd0);
    check("late_lo", lo, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
